uart_rx_fsm: RTL and testbench
==============================

// Module: uart_rx_fsm
// PURPOSE
//  UART receive controller: the receive-side counterpart of the UART TX FSM/serializer.
//  Oversamples RX_IN at Prescale clocks per bit and takes a majority vote of 3 mid-bit samples.
//  Deserializes a frame of start + DATA_WIDTH bits (LSB first) + optional parity + stop.
//  Delivers the byte to the system controller with a one-cycle Data_Valid strobe and reports
//  parity and stop errors.
// PARAMETERS
//  DATA_WIDTH      8   payload bits per frame
//  PRESCALE_WIDTH  6   width of the Prescale port
// PORTS
//  CLK           in   1           RX oversampling clock
//  RST           in   1           asynchronous, active-high reset
//  RX_IN         in   1           serial line, already synchronised to CLK; idles high
//  Prescale      in   PRESCALE_W  clocks per bit; legal values 8, 16, 32
//  PAR_EN        in   1           1 = parity bit present
//  PAR_TYP       in   1           0 = even, 1 = odd
//  P_DATA        out  DATA_WIDTH  received byte; holds its value until the next good frame
//  Data_Valid    out  1           1-cycle pulse: good frame in P_DATA
//  Parity_Error  out  1           1-cycle pulse: parity mismatch
//  Stop_Error    out  1           1-cycle pulse: stop bit sampled 0
// BEHAVIOUR
//  - Reset: state IDLE; counters 0; P_DATA=0; Data_Valid=0; Parity_Error=0; Stop_Error=0.
//    Reset mid-frame aborts the frame with no strobes.
//  - Sampling: edge_cnt runs 0..Prescale-1 within a bit, then wraps and bit_cnt increments.
//    Samples are taken at edges P/2-1, P/2 and P/2+1 (P = latched Prescale).
//    The majority-of-3 bit value is valid from edge P/2+2.
//  - Latching: Prescale, PAR_EN and PAR_TYP are latched at start detection.
//    Changes mid-frame are ignored.
//  - States (gray): IDLE 000, START 001, DATA 011, PARITY 010, STOP 110.
//    * IDLE: RX_IN==0 -> START. The detect cycle counts as edge 0, so edge_cnt<=1.
//    * START: at edge P-1, go to DATA if the voted bit==0.
//      Voted bit==1 is a glitch -> IDLE, no error flags.
//    * DATA: at each edge P/2+2, shift the voted bit into shift_reg[bit_cnt] (LSB first).
//      After bit DATA_WIDTH-1 completes (edge P-1): PAR_EN ? PARITY : STOP.
//    * PARITY: compute expected = ^shift_reg ^ PAR_TYP and compare with the voted bit.
//      Hold the mismatch in par_err_r until the frame ends. Edge P-1 -> STOP.
//    * STOP: stop_err_r = (voted bit==0). Edge P-1 -> IDLE.
//      The next cycle may detect a new start; this gives back-to-back frames with no gap.
//  - Outputs are registered and all strobe in the cycle after the stop bit's edge P-1,
//    i.e. t0 + P*(DATA_WIDTH+2+PAR_EN), where t0 is the detect cycle.
//    * Data_Valid = !par_err_r && !stop_err_r. P_DATA loads shift_reg in the same cycle.
//    * Parity_Error and Stop_Error may pulse together. On error, P_DATA is not updated.
//  - Illegal Prescale values give undefined data, but the FSM must always return to IDLE.
//    Unused state encodings go to IDLE.
// STRUCTURE
//  - uart_rx_pkg: state localparams (gray codes above), PAR_EVEN=0, PAR_ODD=1,
//    and the sample-edge offset constants.
//  - One sub-module, uart_rx_edge_bit_counter:
//    * inputs: enable, Prescale, clear;
//    * outputs: edge_cnt, bit_cnt, bit_done (edge==P-1), sample_strobe[2:0].
//  - The majority vote, deserializer and checks stay inline in this module.
// TESTING
//  1. P=8, PAR_EN=1 even, frame 0xA5 (parity bit 0): Data_Valid=1 exactly at t0+88,
//     P_DATA=0xA5, no error flags.
//  2. P=16, PAR_EN=0, frame 0x3C: Data_Valid at t0+160, P_DATA=0x3C.
//  3. P=8, odd parity, 0x01 sent with parity bit 0: Parity_Error pulses at t0+88,
//     Data_Valid stays 0, P_DATA keeps its previous value.
//  4. P=32, PAR_EN=0, 0xFF with stop bit=0: Stop_Error pulses at t0+320, no Data_Valid.
//  5. Glitch: RX_IN low for 2 cycles at P=8: FSM returns to IDLE at the end of the start bit,
//     no strobes. 1-cycle mid-bit glitch inside a data bit: majority vote rejects it.
//  6. Two back-to-back frames 0x55 then 0xAA, P=8, no gap: two Data_Valid pulses 88 cycles
//     apart. Assert RST mid-second-frame: all outputs 0 at once, no strobe.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_pkg;

  // Gray-coded receive states; adjacent states differ by one bit.
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b011,
    PARITY = 3'b010,
    STOP   = 3'b110
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Sample edges sit around mid-bit: P/2-LEAD, P/2, P/2+LAG.
  localparam int unsigned SAMPLE_LEAD = 1;
  // Distance after P/2 of the last sample.
  localparam int unsigned SAMPLE_LAG  = 1;
  // Edge offset from P/2 at which the voted bit is consumed.
  localparam int unsigned VOTE_LAG    = 2;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Serial line, frame configuration and received-byte strobes of the UART receiver.
interface uart_rx_fsm_if #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6
);
  logic                      RX_IN;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      Data_Valid;
  logic                      Parity_Error;
  logic                      Stop_Error;

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP,
    input  P_DATA, Data_Valid, Parity_Error, Stop_Error
  );

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP,
    output P_DATA, Data_Valid, Parity_Error, Stop_Error
  );
endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and bit counter with mid-bit sample strobes.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = 6,
  parameter int unsigned BIT_WIDTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [BIT_WIDTH-1:0]      bit_cnt,
  output logic                      bit_done,
  output logic [2:0]                sample_strobe
);

  logic [PRESCALE_WIDTH-1:0] last_edge;
  logic [PRESCALE_WIDTH-1:0] half;

  assign last_edge = prescale - PRESCALE_WIDTH'(1);
  assign half      = prescale >> 1;

  // Decode end-of-bit and the three sample positions from the edge count.
  always_comb begin
    bit_done         = (edge_cnt == last_edge);
    sample_strobe[0] = (edge_cnt == half - PRESCALE_WIDTH'(SAMPLE_LEAD));
    sample_strobe[1] = (edge_cnt == half);
    sample_strobe[2] = (edge_cnt == half + PRESCALE_WIDTH'(SAMPLE_LAG));
  end

  // Clear+enable loads edge 1 so the start-detect cycle counts as edge 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (clear) begin
      edge_cnt <= enable ? PRESCALE_WIDTH'(1) : '0;
      bit_cnt  <= '0;
    end else if (enable) begin
      if (bit_done) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + BIT_WIDTH'(1);
      end else begin
        edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller: start detect, majority-vote sampling, deserialize,
// parity/stop checking and registered result strobes.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input logic          CLK,
  input logic          RST,
  uart_rx_fsm_if.slave bus
);

  localparam int unsigned BIT_WIDTH = $clog2(DATA_WIDTH + 3);

  state_t                    state;
  state_t                    next_state;
  logic [PRESCALE_WIDTH-1:0] prescale_r;
  logic                      par_en_r;
  logic                      par_typ_r;
  logic [DATA_WIDTH-1:0]     shift_reg;
  logic [2:0]                samples;
  logic                      par_err_r;
  logic                      stop_err_r;

  logic                      cnt_enable;
  logic                      cnt_clear;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [BIT_WIDTH-1:0]      bit_cnt;
  logic                      bit_done;
  logic [2:0]                sample_strobe;

  logic                      voted;
  logic                      vote_edge;
  logic                      start_seen;
  logic                      frame_end;

  uart_rx_edge_bit_counter #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH),
    .BIT_WIDTH      (BIT_WIDTH)
  ) u_counter (
    .clk           (CLK),
    .rst           (RST),
    .enable        (cnt_enable),
    .clear         (cnt_clear),
    .prescale      (prescale_r),
    .edge_cnt      (edge_cnt),
    .bit_cnt       (bit_cnt),
    .bit_done      (bit_done),
    .sample_strobe (sample_strobe)
  );

  assign voted      = majority3(samples);
  assign vote_edge  = (edge_cnt == (prescale_r >> 1) + PRESCALE_WIDTH'(VOTE_LAG));
  assign start_seen = (state == IDLE) && !bus.RX_IN;
  assign frame_end  = (state == STOP) && bit_done;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and counter control.
  always_comb begin
    next_state = state;
    cnt_enable = 1'b0;
    cnt_clear  = 1'b0;
    case (state)
      IDLE: begin
        cnt_clear = 1'b1;
        if (!bus.RX_IN) begin
          cnt_enable = 1'b1;
          next_state = START;
        end
      end
      START: begin
        cnt_enable = 1'b1;
        if (bit_done) begin
          if (!voted) begin
            // Restart the bit count so it indexes data bits from zero.
            cnt_enable = 1'b0;
            cnt_clear  = 1'b1;
            next_state = DATA;
          end else begin
            next_state = IDLE;
          end
        end
      end
      DATA: begin
        cnt_enable = 1'b1;
        if (bit_done && bit_cnt == BIT_WIDTH'(DATA_WIDTH - 1))
          next_state = par_en_r ? PARITY : STOP;
      end
      PARITY: begin
        cnt_enable = 1'b1;
        if (bit_done) next_state = STOP;
      end
      STOP: begin
        cnt_enable = 1'b1;
        if (bit_done) next_state = IDLE;
      end
      default: begin
        cnt_clear  = 1'b1;
        next_state = IDLE;
      end
    endcase
  end

  // Latch frame configuration at start detect; mid-frame changes are ignored.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prescale_r <= '0;
      par_en_r   <= 1'b0;
      par_typ_r  <= PAR_EVEN;
    end else if (start_seen) begin
      prescale_r <= bus.Prescale;
      par_en_r   <= bus.PAR_EN;
      par_typ_r  <= bus.PAR_TYP;
    end
  end

  // Capture the three mid-bit samples for the majority vote.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      samples <= '0;
    end else if (state != IDLE) begin
      if (sample_strobe[0]) samples[0] <= bus.RX_IN;
      if (sample_strobe[1]) samples[1] <= bus.RX_IN;
      if (sample_strobe[2]) samples[2] <= bus.RX_IN;
    end
  end

  // Deserialize data and evaluate parity/stop once the vote is settled.
  // Right-shift insertion leaves the first (LSB) bit at bit 0 after
  // DATA_WIDTH shifts, equivalent to writing shift_reg[bit_cnt].
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_reg  <= '0;
      par_err_r  <= 1'b0;
      stop_err_r <= 1'b0;
    end else if (start_seen) begin
      par_err_r  <= 1'b0;
      stop_err_r <= 1'b0;
    end else if (vote_edge) begin
      case (state)
        DATA:    shift_reg  <= {voted, shift_reg[DATA_WIDTH-1:1]};
        PARITY:  par_err_r  <= voted != ((^shift_reg) ^ (par_typ_r == PAR_ODD));
        STOP:    stop_err_r <= !voted;
        default: ;
      endcase
    end
  end

  // Registered result strobes; P_DATA updates only on a good frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.P_DATA       <= '0;
      bus.Data_Valid   <= 1'b0;
      bus.Parity_Error <= 1'b0;
      bus.Stop_Error   <= 1'b0;
    end else begin
      bus.Data_Valid   <= 1'b0;
      bus.Parity_Error <= 1'b0;
      bus.Stop_Error   <= 1'b0;
      if (frame_end) begin
        bus.Data_Valid   <= !par_err_r && !stop_err_r;
        bus.Parity_Error <= par_err_r;
        bus.Stop_Error   <= stop_err_r;
        if (!par_err_r && !stop_err_r) bus.P_DATA <= shift_reg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: frames are driven bit by bit, the
// expected strobe is queued at start, a monitor pops and compares.
module tb_uart_rx_fsm;
  import uart_rx_pkg::*;

  typedef struct {
    int unsigned cyc;
    logic        dv;
    logic        pe;
    logic        se;
    logic [7:0]  data;
  } exp_t;

  logic        clk;
  logic        rst;
  int unsigned cyc;
  int unsigned passed;
  int unsigned total;
  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned tg;

  uart_rx_fsm_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) bus ();

  uart_rx_fsm #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.RX_IN = 1'b1;
    end
  endtask

  // Drive one frame; queue its expected strobe unless the frame is aborted by reset.
  task automatic send_frame(input logic [7:0] data, input logic [5:0] p,
                            input logic par_en, input logic par_typ, input logic par_bit,
                            input logic stop_bit, input int glitch_bit, input logic scramble,
                            input int abort_at, input logic exp_dv, input logic exp_pe,
                            input logic exp_se, input logic [7:0] exp_data);
    logic [10:0] bits;
    int          nbits;
    exp_t        e;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = data;
    if (par_en) begin
      bits[9]  = par_bit;
      bits[10] = stop_bit;
      nbits    = 11;
    end else begin
      bits[9]  = stop_bit;
      nbits    = 10;
    end
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < int'(p); k++) begin
        @(negedge clk);
        if (b == 0 && k == 0) begin
          bus.Prescale = p;
          bus.PAR_EN   = par_en;
          bus.PAR_TYP  = par_typ;
          if (abort_at < 0) begin
            e.cyc  = cyc + int'(p) * nbits;
            e.dv   = exp_dv;
            e.pe   = exp_pe;
            e.se   = exp_se;
            e.data = exp_data;
            sb.push_back(e);
          end
        end
        if (scramble && b == 1 && k == 0) begin
          bus.Prescale = p ^ 6'd24;
          bus.PAR_EN   = ~par_en;
          bus.PAR_TYP  = ~par_typ;
        end
        if (abort_at >= 0 && b * int'(p) + k == abort_at) begin
          rst = 1'b1;
          #1;
          check("reset_abort_p_data", 32'(bus.P_DATA), 32'h0);
          check("reset_abort_strobes",
                {29'd0, bus.Data_Valid, bus.Parity_Error, bus.Stop_Error}, 32'h0);
          check("reset_abort_state", 32'(dut.state), 32'(IDLE));
          return;
        end
        bus.RX_IN = bits[b] ^ (b == glitch_bit && k == int'(p) / 2);
      end
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst          = 1'b1;
    bus.RX_IN    = 1'b1;
    bus.Prescale = 6'd8;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_p_data", 32'(bus.P_DATA), 32'h0);
    check("reset_data_valid", 32'(bus.Data_Valid), 32'h0);
    check("reset_parity_error", 32'(bus.Parity_Error), 32'h0);
    check("reset_stop_error", 32'(bus.Stop_Error), 32'h0);
    check("reset_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (bus.Data_Valid || bus.Parity_Error || bus.Stop_Error) begin
            if (sb.size() == 0) begin
              check("spurious_strobe",
                    {29'd0, bus.Data_Valid, bus.Parity_Error, bus.Stop_Error}, 32'h0);
            end else begin
              mon_e = sb.pop_front();
              check("strobe_cycle", cyc, mon_e.cyc);
              check("data_valid", 32'(bus.Data_Valid), 32'(mon_e.dv));
              check("parity_error", 32'(bus.Parity_Error), 32'(mon_e.pe));
              check("stop_error", 32'(bus.Stop_Error), 32'(mon_e.se));
              check("p_data", 32'(bus.P_DATA), 32'(mon_e.data));
            end
          end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
            mon_e = sb.pop_front();
            check("strobe_missing_at_cycle", cyc - 1, mon_e.cyc);
          end
        end
      end
    join_none

    idle(4);
    // 0xA5, P=8, even parity bit 0: strobe at t0+88
    send_frame(8'hA5, 6'd8, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1, 1'b0, -1, 1'b1, 1'b0, 1'b0, 8'hA5);
    idle(5);
    // 0x3C, P=16, no parity, config scrambled mid-frame: strobe at t0+160
    send_frame(8'h3C, 6'd16, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'h3C);
    idle(5);
    // 0x01, odd parity needs parity bit 0; bit 1 sent -> Parity_Error, P_DATA holds 0x3C
    send_frame(8'h01, 6'd8, 1'b1, PAR_ODD, 1'b1, 1'b1, -1, 1'b0, -1, 1'b0, 1'b1, 1'b0, 8'h3C);
    idle(5);
    // 0xFF, P=32, stop bit 0: Stop_Error at t0+320
    send_frame(8'hFF, 6'd32, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1, 1'b0, -1, 1'b0, 1'b0, 1'b1, 8'h3C);
    idle(5);
    // 0x07 even parity needs 1; send 0 and stop 0: both errors together
    send_frame(8'h07, 6'd8, 1'b1, PAR_EVEN, 1'b0, 1'b0, -1, 1'b0, -1, 1'b0, 1'b1, 1'b1, 8'h3C);
    idle(5);

    // Start glitch: 2 low cycles at P=8, back to IDLE after edge 7
    @(negedge clk);
    bus.Prescale = 6'd8;
    bus.RX_IN    = 1'b0;
    tg           = cyc;
    @(negedge clk);
    bus.RX_IN = 1'b0;
    repeat (5) begin
      @(negedge clk);
      bus.RX_IN = 1'b1;
    end
    @(negedge clk);
    check("glitch_start_cycle", cyc, tg + 7);
    check("glitch_still_start", 32'(dut.state), 32'(START));
    @(negedge clk);
    check("glitch_back_idle", 32'(dut.state), 32'(IDLE));
    idle(12);

    // 0x96 with a 1-cycle glitch at mid-sample of data bit 2: vote rejects it
    send_frame(8'h96, 6'd8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 3, 1'b0, -1, 1'b1, 1'b0, 1'b0, 8'h96);
    idle(5);

    // Back-to-back 0x55, 0xAA (even parity 0), then a third frame cut by reset
    send_frame(8'h55, 6'd8, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1, 1'b0, -1, 1'b1, 1'b0, 1'b0, 8'h55);
    send_frame(8'hAA, 6'd8, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1, 1'b0, -1, 1'b1, 1'b0, 1'b0, 8'hAA);
    send_frame(8'h0F, 6'd8, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1, 1'b0, 40, 1'b0, 1'b0, 1'b0, 8'h00);
    bus.RX_IN = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(100);

    // Recovery frame after reset
    send_frame(8'hC3, 6'd8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 1'b0, -1, 1'b1, 1'b0, 1'b0, 8'hC3);
    idle(20);
    check("scoreboard_drained", sb.size(), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
